// File: rtl/rs_hs_pipeline_param.sv
// rs_hs_pipeline_param
//   Long-haul valid/ready relay. Beats accepted at the head travel through
//   S never-stalling forward register stages into a tail FIFO. The tail's
//   "has room" signal returns to the head through R ready registers. The
//   FIFO holds GRACE_PERIOD = S+R extra entries, so beats still in flight
//   when the head closes always fit.
//
//   Parameters: DATA_WIDTH, DEPTH, BODY_LEVEL, PIPELINE_READY_IN_HEAD,
//               PIPELINE_VALID_AND_DATA_IN_HEAD (the rest are derived)
//   Ports:
//     clk        - clock; all state changes on the rising edge
//     reset      - asynchronous reset, active low
//     in_valid   - upstream beat valid
//     in_ready   - upstream ready (registered when R>0)
//     in_data    - upstream payload
//     out_valid  - downstream beat valid (FIFO not empty)
//     out_ready  - downstream ready
//     out_data   - FIFO head, first-word fall-through; 0 when empty
//     occupancy  - current FIFO count
//   Optional (macro RS_HS_PP_OCC_MON_EN):
//     max_occupancy - high-water mark of occupancy
//     overflow_err  - sticky flag for a push into a full FIFO
module rs_hs_pipeline_param #(
   parameter int unsigned DATA_WIDTH                      = 32,
   parameter int unsigned DEPTH                           = 24,
   parameter int unsigned BODY_LEVEL                      = 4,
   parameter int unsigned PIPELINE_READY_IN_HEAD          = 1,
   parameter int unsigned PIPELINE_VALID_AND_DATA_IN_HEAD = 0,
   localparam int unsigned S            = BODY_LEVEL + PIPELINE_VALID_AND_DATA_IN_HEAD,
   localparam int unsigned R            = BODY_LEVEL + PIPELINE_READY_IN_HEAD,
   localparam int unsigned GRACE_PERIOD = S + R,
   localparam int unsigned REAL_DEPTH   = GRACE_PERIOD + DEPTH + 4,
   localparam int unsigned ADDR_WIDTH   = $clog2(REAL_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [ADDR_WIDTH-1:0] occupancy
`ifdef RS_HS_PP_OCC_MON_EN
   ,
   output logic [ADDR_WIDTH-1:0] max_occupancy,
   output logic                  overflow_err
`endif
);

   localparam int unsigned PTR_W = $clog2(REAL_DEPTH);
   localparam logic [ADDR_WIDTH-1:0] DEPTH_C = ADDR_WIDTH'(DEPTH);
   localparam logic [ADDR_WIDTH-1:0] FULL_C  = ADDR_WIDTH'(REAL_DEPTH);
   localparam logic [PTR_W-1:0]      LAST_C  = PTR_W'(REAL_DEPTH - 1);

   logic                  accept;
   logic                  tail_valid;
   logic [DATA_WIDTH-1:0] tail_data;
   logic                  tail_ready;

   always_comb begin
      accept = in_valid & in_ready;
   end

   // ---------------- forward path ----------------
   if (S == 0) begin : g_no_fwd
      always_comb begin
         tail_valid = accept;
         tail_data  = in_data;
      end
   end else begin : g_fwd
      logic [S-1:0]                 fwd_valid_q, fwd_valid_d;
      logic [S-1:0][DATA_WIDTH-1:0] fwd_data_q, fwd_data_d;

      if (S == 1) begin : g_one
         always_comb begin
            fwd_valid_d = accept;
            fwd_data_d  = in_data;
         end
      end else begin : g_many
         always_comb begin
            fwd_valid_d = {fwd_valid_q[S-2:0], accept};
            fwd_data_d  = {fwd_data_q[S-2:0], in_data};
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) fwd_valid_q <= '0;
         else        fwd_valid_q <= fwd_valid_d;
      end

      // Payload qualified by the valid bits, so it needs no reset.
      always_ff @(posedge clk) begin
         fwd_data_q <= fwd_data_d;
      end

      always_comb begin
         tail_valid = fwd_valid_q[S-1];
         tail_data  = fwd_data_q[S-1];
      end
   end

   // ---------------- backward (ready) path ----------------
   if (R == 0) begin : g_no_rdy
      always_comb begin
         in_ready = tail_ready;
      end
   end else begin : g_rdy
      logic [R-1:0] rdy_q, rdy_d;

      if (R == 1) begin : g_one
         always_comb begin
            rdy_d = tail_ready;
         end
      end else begin : g_many
         always_comb begin
            rdy_d = {rdy_q[R-2:0], tail_ready};
         end
      end

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) rdy_q <= '0;
         else        rdy_q <= rdy_d;
      end

      always_comb begin
         in_ready = rdy_q[R-1];
      end
   end

   // ---------------- tail FIFO ----------------
   logic [DATA_WIDTH-1:0] mem_q [REAL_DEPTH];
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [ADDR_WIDTH-1:0] count_q, count_d;
   logic                  push, pop;

   always_comb begin
      tail_ready = (count_q <= DEPTH_C);
      out_valid  = (count_q != '0);
      occupancy  = count_q;
      out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
      // A beat arriving at a full FIFO is dropped; unreachable with the grace slack.
      push       = tail_valid & (count_q != FULL_C);
      pop        = out_valid & out_ready;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = (wr_ptr_q == LAST_C) ? '0 : wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = (rd_ptr_q == LAST_C) ? '0 : rd_ptr_q + PTR_W'(1);
      case ({push, pop})
         2'b10:   count_d = count_q + ADDR_WIDTH'(1);
         2'b01:   count_d = count_q - ADDR_WIDTH'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= tail_data;
   end

`ifdef RS_HS_PP_OCC_MON_EN
   // ---------------- occupancy monitor ----------------
   logic [ADDR_WIDTH-1:0] max_occ_q, max_occ_d;
   logic                  ovf_q, ovf_d;

   always_comb begin
      max_occ_d = (count_q > max_occ_q) ? count_q : max_occ_q;
      ovf_d     = ovf_q | (tail_valid & (count_q == FULL_C));
      max_occupancy = max_occ_q;
      overflow_err  = ovf_q;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         max_occ_q <= '0;
         ovf_q     <= 1'b0;
      end else begin
         max_occ_q <= max_occ_d;
         ovf_q     <= ovf_d;
      end
   end
`endif

endmodule

// File: tb/tb_rs_hs_pipeline_param.sv
module tb_rs_hs_pipeline_param;

   localparam int unsigned DW = 32;
   localparam int unsigned AW = $clog2(4 + 5 + 24 + 4) + 1;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [DW-1:0] in_data = '0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [DW-1:0] out_data;
   logic [AW-1:0] occupancy;
`ifdef RS_HS_PP_OCC_MON_EN
   logic [AW-1:0] max_occupancy;
   logic          overflow_err;
`endif

   rs_hs_pipeline_param #(
      .DATA_WIDTH(DW),
      .DEPTH(24),
      .BODY_LEVEL(4),
      .PIPELINE_READY_IN_HEAD(1),
      .PIPELINE_VALID_AND_DATA_IN_HEAD(0)
   ) dut (
      .clk(clk),
      .reset(reset),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .in_data(in_data),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data(out_data),
      .occupancy(occupancy)
`ifdef RS_HS_PP_OCC_MON_EN
      ,
      .max_occupancy(max_occupancy),
      .overflow_err(overflow_err)
`endif
   );

   always #5 clk = ~clk;

   int            n_cmp = 0;
   int            n_err = 0;
   logic [DW-1:0] sb[$];
   int            max_seen = 0;
   logic          want_first = 1'b0;
   logic [DW-1:0] first_out = '0;
   int            n_acc;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: expected beats enter on accept, leave on pop.
   always @(negedge clk) begin
      if (reset) begin
         if (int'(occupancy) > max_seen) max_seen = int'(occupancy);
         if (in_valid && in_ready) sb.push_back(in_data);
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_err++;
               $display("FAIL sb_underflow: got %0h expected no beat", out_data);
            end else begin
               if (want_first) begin
                  first_out  = out_data;
                  want_first = 1'b0;
               end
               chk("sb_data", out_data, sb.pop_front());
            end
         end
      end
   end

   // One cycle of feeding: data advances only after an accepted beat.
   task automatic step_feed();
      logic a;
      @(negedge clk);
      a = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (a) begin
         n_acc++;
         in_data = in_data + 1;
      end
   endtask

   initial begin
      int c0, c1, cnt;

      // ---- reset state ----
      #12;
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_occupancy", occupancy, 0);
      chk("rst_out_data", out_data, 0);
      @(posedge clk);
      #1;
      reset = 1'b1;
      for (int e = 1; e <= 5; e++) begin
         @(posedge clk);
         #1;
         chk("rel_in_ready", in_ready, (e == 5) ? 1 : 0);
         chk("rel_out_valid", out_valid, 0);
         chk("rel_occupancy", occupancy, 0);
      end

      // ---- single beat latency ----
      in_valid  = 1'b1;
      in_data   = 32'hA5A5_0001;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk("lat_out_valid_0", out_valid, 0);
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk);
         #1;
         chk("lat_out_valid", out_valid, (k == 4) ? 1 : 0);
      end
      chk("lat_out_data", out_data, 32'hA5A5_0001);
      @(posedge clk);
      #1;
      chk("lat_occ_after", occupancy, 0);
      chk("lat_valid_after", out_valid, 0);

      // ---- fill with out_ready low ----
      out_ready = 1'b0;
      in_data   = '0;
      in_valid  = 1'b1;
      n_acc     = 0;
      repeat (60) step_feed();
      chk("fill_accepts", n_acc, 34);
      chk("fill_occupancy", occupancy, 34);
      chk("fill_in_ready", in_ready, 0);
`ifdef RS_HS_PP_OCC_MON_EN
      chk("fill_max_occ", max_occupancy, 34);
      chk("fill_ovf", overflow_err, 0);
`endif

      // ---- drain: 0..33 in order, ready returns 5 cycles after room ----
      in_valid  = 1'b0;
      out_ready = 1'b1;
      c0 = -1;
      c1 = -1;
      for (int c = 0; c < 60; c++) begin
         @(negedge clk);
         if (c0 < 0 && occupancy <= 24) c0 = c;
         if (c1 < 0 && in_ready) c1 = c;
      end
      chk("drain_ready_delay", c1 - c0, 5);
      chk("drain_sb_empty", sb.size(), 0);
      chk("drain_occupancy", occupancy, 0);

      // ---- random traffic ----
      @(posedge clk);
      #1;
      n_acc   = 0;
      in_data = 32'h0010_0000;
      for (int c = 0; c < 60000 && n_acc < 10000; c++) begin
         in_valid  = ($urandom_range(0, 1) == 1);
         out_ready = ($urandom_range(0, 9) < 3);
         step_feed();
      end
      chk("rand_accepts", n_acc, 10000);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      cnt = 0;
      while ((sb.size() != 0 || out_valid) && cnt < 200) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      chk("rand_sb_empty", sb.size(), 0);
      chk("rand_max_occ", (max_seen <= 34) ? 1 : 0, 1);

      // ---- reset mid-stream at occupancy 20 ----
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 32'h2000_0000;
      cnt = 0;
      while (occupancy != 20 && cnt < 100) begin
         step_feed();
         cnt++;
      end
      chk("mid_occ_reached", occupancy, 20);
      #1;
      reset = 1'b0;
      #1;
      chk("mid_in_ready", in_ready, 0);
      chk("mid_out_valid", out_valid, 0);
      chk("mid_occupancy", occupancy, 0);
      chk("mid_out_data", out_data, 0);
`ifdef RS_HS_PP_OCC_MON_EN
      chk("mid_max_occ", max_occupancy, 0);
`endif
      sb.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset      = 1'b1;
      in_data    = 32'h3000_0000;
      in_valid   = 1'b1;
      out_ready  = 1'b1;
      want_first = 1'b1;
      repeat (40) step_feed();
      in_valid = 1'b0;
      repeat (40) @(posedge clk);
      #1;
      chk("post_first_out", first_out, 32'h3000_0000);
      chk("post_sb_empty", sb.size(), 0);
      chk("post_occupancy", occupancy, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
